// File: rtl/mmio_defines.sv
// Shared definitions for the MMIO peripheral window:
// address map, STATUS bit positions and UART FSM states.
package mmio_defines;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hF000_0000;

  localparam logic [5:0] MMIO_LEDS    = 6'h00;
  localparam logic [5:0] MMIO_CYCLES  = 6'h04;
  localparam logic [5:0] MMIO_TX_DATA = 6'h08;
  localparam logic [5:0] MMIO_STATUS  = 6'h0C;
  localparam logic [5:0] MMIO_CMP     = 6'h10;
  localparam logic [5:0] MMIO_FLAG    = 6'h14;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVERRUN = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmit shifter with registered line output.
// ready marks the cycles in which a pending byte is taken.
module uart_tx_8n1
  import mmio_defines::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          last;

  assign last  = (baud_q == BAUD_LAST);
  assign ready = (state_q == S_IDLE) ||
                 ((state_q == S_STOP) && last);
  assign busy  = (state_q != S_IDLE);
  assign tx    = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = data;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (last) begin
          baud_d = '0;
          if (start) begin
            shift_d = data;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the next state so tx is a clean flop output
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/mmio_peripherals.sv
// MMIO window: LED register, cycle counter with compare flag
// and a UART transmitter behind a one-deep holding register.
module mmio_peripherals
  import mmio_defines::*;
#(
  parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DEFAULT,
  parameter int          LED_WIDTH    = 8,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wr_data,
  input  logic                 mem_wr_ena,
  output logic [31:0]          rd_data,
  output logic                 hit,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 uart_tx
);

  logic [5:0] off;
  logic sel_leds, sel_cycles, sel_tx;
  logic sel_status, sel_cmp, sel_flag;
  logic wr_leds, wr_cycles, wr_tx;
  logic wr_status, wr_cmp, wr_flag;

  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic [7:0]  hold_q, hold_d;
  logic        full_q, full_d;
  logic        ovr_q, ovr_d;

  logic        tx_ready, tx_busy, take;
  logic [31:0] status;

  assign hit = (mem_addr[31:6] == MMIO_BASE[31:6]);
  assign off = mem_addr[5:0];

  // Full-offset match also rejects misaligned accesses
  assign sel_leds   = hit && (off == MMIO_LEDS);
  assign sel_cycles = hit && (off == MMIO_CYCLES);
  assign sel_tx     = hit && (off == MMIO_TX_DATA);
  assign sel_status = hit && (off == MMIO_STATUS);
  assign sel_cmp    = hit && (off == MMIO_CMP);
  assign sel_flag   = hit && (off == MMIO_FLAG);

  assign wr_leds   = mem_wr_ena & sel_leds;
  assign wr_cycles = mem_wr_ena & sel_cycles;
  assign wr_tx     = mem_wr_ena & sel_tx;
  assign wr_status = mem_wr_ena & sel_status;
  assign wr_cmp    = mem_wr_ena & sel_cmp;
  assign wr_flag   = mem_wr_ena & sel_flag;

  assign take = full_q & tx_ready;
  assign leds = leds_q;

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(full_q),
    .data (hold_q),
    .ready(tx_ready),
    .busy (tx_busy),
    .tx   (uart_tx)
  );

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = tx_busy;
    status[ST_FULL]     = full_q;
    status[ST_OVERRUN]  = ovr_q;
  end

  always_comb begin
    leds_d = wr_leds ? mem_wr_data[LED_WIDTH-1:0] : leds_q;
    cyc_d  = wr_cycles ? 32'd0 : cyc_q + 32'd1;
    cmp_d  = wr_cmp ? mem_wr_data : cmp_q;
    flag_d = (cyc_d == cmp_q) |
             (flag_q & ~(wr_flag & mem_wr_data[0]));
    hold_d = hold_q;
    full_d = full_q;
    ovr_d  = ovr_q;
    if (take) begin
      full_d = 1'b0;
    end
    // A write landing on the take cycle refills the slot
    if (wr_tx) begin
      if (!full_q || take) begin
        hold_d = mem_wr_data[7:0];
        full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (wr_status && mem_wr_data[ST_OVERRUN]) begin
      ovr_d = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_leds:   rd_data = 32'(leds_q);
      sel_cycles: rd_data = cyc_q;
      sel_status: rd_data = status;
      sel_cmp:    rd_data = cmp_q;
      sel_flag:   rd_data = {31'b0, flag_q};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds_q <= '0;
      cyc_q  <= '0;
      cmp_q  <= 32'hFFFF_FFFF;
      flag_q <= 1'b0;
      hold_q <= '0;
      full_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      cyc_q  <= cyc_d;
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
      hold_q <= hold_d;
      full_q <= full_d;
      ovr_q  <= ovr_d;
    end
  end

endmodule

// File: tb/tb_mmio_peripherals.sv
// Directed bench for mmio_peripherals with CLKS_PER_BIT=4
// and LED_WIDTH=8; expected values are hand-derived constants.
module tb_mmio_peripherals;

  localparam logic [31:0] A_LEDS   = 32'hF000_0000;
  localparam logic [31:0] A_CYC    = 32'hF000_0004;
  localparam logic [31:0] A_TX     = 32'hF000_0008;
  localparam logic [31:0] A_STAT   = 32'hF000_000C;
  localparam logic [31:0] A_CMP    = 32'hF000_0010;
  localparam logic [31:0] A_FLAG   = 32'hF000_0014;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] rd_data;
  logic        hit;
  logic [7:0]  leds;
  logic        uart_tx;

  int n_cmp;
  int n_err;

  mmio_peripherals #(
    .MMIO_BASE   (32'hF000_0000),
    .LED_WIDTH   (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_ena (mem_wr_ena),
    .rd_data    (rd_data),
    .hit        (hit),
    .leds       (leds),
    .uart_tx    (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    mem_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr    = a;
    mem_wr_data = d;
    mem_wr_ena  = 1'b1;
    @(posedge clk);
    #1;
    mem_wr_ena = 1'b0;
  endtask

  // Line level j cycles into a frame carrying byte b (4 clk/bit)
  function automatic logic fbit(input logic [7:0] b, input int j);
    if (j < 4) return 1'b0;
    if (j < 36) return b[(j - 4) / 4];
    return 1'b1;
  endfunction

  // Called right after the TX_DATA write edge
  task automatic check_frame(input string tag, input logic [7:0] b);
    @(negedge clk);
    chk({tag, "_pre"}, 32'(uart_tx), 32'd1);
    mem_addr = A_STAT;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk({tag, "_tx"}, 32'(uart_tx), 32'(fbit(b, i)));
      chk({tag, "_busy"}, 32'(rd_data[0]), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_idle_tx"}, 32'(uart_tx), 32'd1);
    rd_chk({tag, "_idle_st"}, A_STAT, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b0;
    mem_addr    = 32'h0;
    mem_wr_data = 32'h0;
    mem_wr_ena  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    rd_chk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rst = 1'b1;

    @(negedge clk);
    rd_chk("idle_status", A_STAT, 32'h0);
    rd_chk("idle_flag", A_FLAG, 32'h0);
    bus_wr(A_CYC, 32'h1234);
    @(negedge clk);
    rd_chk("cyc0", A_CYC, 32'd0);
    @(negedge clk);
    rd_chk("cyc1", A_CYC, 32'd1);
    repeat (5) @(negedge clk);
    rd_chk("cyc6", A_CYC, 32'd6);
    rd_chk("ram_rd", 32'h2000_0000, 32'h0);
    chk("ram_hit", 32'(hit), 32'd0);
    rd_chk("top_rd", 32'hF000_003C, 32'h0);
    chk("top_hit", 32'(hit), 32'd1);
    mem_addr = 32'hF000_0040;
    #1;
    chk("past_hit", 32'(hit), 32'd0);
    mem_addr = 32'hEFFF_FFFC;
    #1;
    chk("below_hit", 32'(hit), 32'd0);

    bus_wr(A_LEDS, 32'hFFFF_FFA5);
    @(negedge clk);
    chk("leds_a5", 32'(leds), 32'hA5);
    rd_chk("leds_rd", A_LEDS, 32'h0000_00A5);
    bus_wr(32'hF000_0001, 32'h0000_00FF);
    @(negedge clk);
    chk("leds_misal", 32'(leds), 32'hA5);
    rd_chk("misal_rd", 32'hF000_0005, 32'h0);
    rd_chk("txdata_rd", A_TX, 32'h0);

    bus_wr(A_TX, 32'h55);
    check_frame("f55", 8'h55);

    // Three back-to-back writes: 2nd lands on the take cycle
    @(negedge clk);
    mem_addr    = A_TX;
    mem_wr_ena  = 1'b1;
    mem_wr_data = 32'h41;
    @(negedge clk);
    mem_wr_data = 32'h42;
    @(negedge clk);
    mem_wr_data = 32'h43;
    @(negedge clk);
    mem_wr_ena = 1'b0;
    rd_chk("ovr_status", A_STAT, 32'h7);
    for (int i = 1; i < 80; i++) begin
      if (i > 1) @(negedge clk);
      chk(i < 40 ? "b2b_tx41" : "b2b_tx42", 32'(uart_tx),
          32'(fbit(i < 40 ? 8'h41 : 8'h42, i % 40)));
      if (i == 40) rd_chk("b2b_status", A_STAT, 32'h5);
    end
    @(negedge clk);
    chk("b2b_end_tx", 32'(uart_tx), 32'd1);
    rd_chk("b2b_end_st", A_STAT, 32'h4);
    bus_wr(A_STAT, 32'h4);
    @(negedge clk);
    rd_chk("ovr_clr", A_STAT, 32'h0);

    bus_wr(A_CMP, 32'd20);
    bus_wr(A_CYC, 32'h0);
    @(negedge clk);
    rd_chk("cmp_c0", A_CYC, 32'd0);
    rd_chk("cmp_f0", A_FLAG, 32'd0);
    repeat (19) @(negedge clk);
    rd_chk("cmp_c19", A_CYC, 32'd19);
    rd_chk("cmp_f19", A_FLAG, 32'd0);
    // Clear on the same edge the flag sets
    mem_addr    = A_FLAG;
    mem_wr_data = 32'h1;
    mem_wr_ena  = 1'b1;
    @(posedge clk);
    #1;
    mem_wr_ena = 1'b0;
    @(negedge clk);
    rd_chk("cmp_setwin", A_FLAG, 32'd1);
    rd_chk("cmp_c20", A_CYC, 32'd20);
    bus_wr(A_FLAG, 32'h1);
    @(negedge clk);
    rd_chk("flag_clr", A_FLAG, 32'd0);
    rd_chk("cmp_rd", A_CMP, 32'd20);
    bus_wr(A_CMP, 32'h0);
    bus_wr(A_CYC, 32'h0);
    @(negedge clk);
    rd_chk("flag_zero", A_FLAG, 32'd1);

    bus_wr(A_TX, 32'hC3);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tx", 32'(uart_tx), 32'd1);
    chk("arst_leds", 32'(leds), 32'h0);
    rd_chk("arst_stat", A_STAT, 32'h0);
    rd_chk("arst_flag", A_FLAG, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus_wr(A_TX, 32'h3C);
    check_frame("f3c", 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_peripherals.md
Name: mmio_peripherals

Overview:
- Memory-mapped peripheral block on the multicycle core's data/instruction memory bus, in parallel with main RAM.
- Decodes the core's word address; provides an LED register, a free-running cycle counter with compare flag, and an 8N1 UART transmitter with a one-deep holding register.
- Reads are combinational, matching the core's same-cycle capture of read data. Writes commit on the clock edge.
- The top level muxes rd_data against RAM using the hit output.

Parameters:
- MMIO_BASE, 32'hF000_0000, base byte address of the 64-byte peripheral window.
- LED_WIDTH, 8, width of the LED output register (1..32).
- CLKS_PER_BIT, 868, clock cycles per UART bit (>=2).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- mem_addr  input  32  byte address from core
- mem_wr_data  input  32  write data from core
- mem_wr_ena  input  1  write strobe from core
- rd_data  output  32  combinational read data (0 when not hit)
- hit  output  1  mem_addr within [MMIO_BASE, MMIO_BASE+64)
- leds  output  LED_WIDTH  LED register contents
- uart_tx  output  1  serial line, idle high

Behaviour:
- Decode: hit = (mem_addr[31:6] == MMIO_BASE[31:6]); offset = mem_addr[5:0]; an access with offset[1:0] != 0 is ignored (reads 0, no write).
- Write qualifier: wr = mem_wr_ena & hit & aligned; takes effect at the next rising clk.
- Register map (offset: access, function):
  - 0x00 LEDS: RW; bits [LED_WIDTH-1:0]; upper bits read 0.
  - 0x04 CYCLES: RO count, +1 every clk, wraps 0xFFFF_FFFF -> 0; any write loads 0 (the write wins over the increment that cycle).
  - 0x08 TX_DATA: write enqueues mem_wr_data[7:0]; reads 0.
  - 0x0C STATUS: read {29'b0, overrun, full, busy}; a write with bit2=1 clears overrun.
  - 0x10 CMP: RW 32-bit compare value.
  - 0x14 FLAG: read bit0 = match flag; a write with bit0=1 clears it.
  - 0x18-0x3C: read 0, writes ignored.
- Compare: the flag sets on the edge where the counter's next value equals CMP.
  - If a set and a clear occur in the same cycle, set wins.
- UART holding register (full bit):
  - A TX_DATA write while full=0 loads hold and sets full.
  - A TX_DATA write while full=1 drops the byte and sets sticky overrun.
  - The shifter takes hold when idle or at stop-bit end, clearing full that edge. A TX_DATA write in the same cycle as that take is accepted (full stays 1).
- UART FSM states: S_IDLE, S_START, S_DATA, S_STOP; a baud counter 0..CLKS_PER_BIT-1 and bit index 0..7.
  - S_IDLE: uart_tx=1; when full, load shift reg and go to S_START next cycle.
  - S_START: uart_tx=0 for CLKS_PER_BIT cycles.
  - S_DATA: LSB first, each bit CLKS_PER_BIT cycles.
  - S_STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then go to S_START if full (back-to-back, no idle gap), else S_IDLE.
  - busy = (state != S_IDLE).
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Reset (rst=0, asynchronous, any time including mid-frame): leds=0, CYCLES=0, CMP=0xFFFF_FFFF, flag=0, full=0, overrun=0, state=S_IDLE, uart_tx=1 immediately, counters=0. rd_data stays purely combinational.
- uart_tx is driven from a flop (glitch-free).

Decomposition:
- Shared package mmio_defines:
  - MMIO_BASE default.
  - Offset constants (MMIO_LEDS, MMIO_CYCLES, MMIO_TX_DATA, MMIO_STATUS, MMIO_CMP, MMIO_FLAG).
  - STATUS bit indices.
  - uart_state_t enum.
- Sub-module uart_tx_8n1 (ports: clk, rst, start, data[7:0], ready, busy, tx). The holding register, full and overrun stay in mmio_peripherals.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: leds=0, uart_tx=1, STATUS reads 0. CYCLES read at 0xF000_0004 increments by 1 per cycle; read at 0x2000_0000 gives hit=0, rd_data=0.
- Write 0xA5 to 0xF000_0000 with LED_WIDTH=8 -> leds=0xA5 next cycle, readback 0x0000_00A5. Misaligned write to 0xF000_0001 -> leds unchanged.
- Write 0x55 to TX_DATA -> uart_tx low for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. busy=1 for 40 cycles total.
- Write 0x41, 0x42, 0x43 on consecutive write cycles:
  - 0x41 and 0x42 are sent back-to-back (80 cycles, no idle gap).
  - 0x43 is dropped with STATUS=0b111 after the third write.
  - Writing 0x4 to STATUS clears overrun.
- CMP=20 and CYCLES cleared by write -> FLAG bit0=1 from the cycle after CYCLES reads 19 onward. Writing 1 to FLAG clears it; it sets again after the counter wraps.
- Assert rst=0 mid-frame (during S_DATA) -> uart_tx=1 asynchronously, busy=0, full=0. After release, a fresh write transmits a complete frame.
